uart_tx_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 82 ++++++++
 rtl/uart_tx_buffered.sv | 146 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit types and board timing constants.
// The default bit period is derived from the 32.256 MHz board clock and 115200 baud.
package uart_pkg;

    localparam int DATA_BITS    = 8;
    localparam int BOARD_CLK_HZ = 32_256_000;
    localparam int DEFAULT_BAUD = 115_200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Round to the nearest whole clock so an awkward ratio errs toward the true baud rate.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int DEFAULT_CLKS_PER_BIT = clks_per_bit(BOARD_CLK_HZ, DEFAULT_BAUD);

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte queue that feeds the UART serializer.
// ready_o and level_o come straight from flops, so the stream side never sees a combinational path.
module uart_tx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ready_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] level_next_o
);

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             do_push;
    logic             do_pop;

    // push_i is a raw request; it only lands when the registered ready says there is room.
    always_comb begin
        do_push  = push_i && ready_q;
        do_pop   = pop_i && (level_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        ready_d = (level_d != FULL_LEVEL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    assign rdata_o      = mem_q[rd_ptr_q];
    assign ready_o      = ready_q;
    assign empty_o      = (level_q == '0);
    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: stream bytes in, queue them, shift them out LSB first.
// Frames chain with no idle gap while the queue holds data.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter  int FIFO_DEPTH   = 4,
    parameter  int STOP_BITS    = 1,
    localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic [LVL_W-1:0]     level_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;

    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [LVL_W-1:0]     fifo_level_next;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wdata_i      (data_i),
        .push_i       (valid_i),
        .pop_i        (fifo_pop),
        .rdata_o      (fifo_rdata),
        .ready_o      (ready_o),
        .empty_o      (fifo_empty),
        .level_o      (level_o),
        .level_next_o (fifo_level_next)
    );

    // tx_d is the value the pin takes after this edge, so every transition lands on the state change.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        bit_done   = (cnt_q == CNT_LAST);
        cnt_d      = (state_q == IDLE || bit_done) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_q[idx_q + IDX_W'(1)];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            state_d  = START;
                            tx_d     = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE) || (fifo_level_next != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed and random bytes, checked against a UART line model
// and a mid-bit sampling receiver that decodes whatever appears on tx_o.
module tb_uart_tx_buffered;

    localparam int CPB    = 280;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int FRAME1 = 10 * CPB;
    localparam int FRAME2 = 11 * CPB;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       data_i, data2;
    logic             valid_i, valid2;
    logic             ready, ready2;
    logic             tx, tx2;
    logic             busy, busy2;
    logic [LVL_W-1:0] level, level2;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         frame_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready),
        .tx_o    (tx),
        .busy_o  (busy),
        .level_o (level)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data2),
        .valid_i (valid2),
        .ready_o (ready2),
        .tx_o    (tx2),
        .busy_o  (busy2),
        .level_o (level2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level t cycles after the start bit began: start, 8 data bits LSB first, then stop.
    function automatic logic expTx(input logic [7:0] b, input int t);
        int slot;
        slot = t / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds valid_i with the byte until an edge accepts it; returns that edge's index.
    task automatic applyStimulus(input logic [7:0] b, output int acc_cyc);
        logic r;
        bit   ok;
        ok      = 1'b0;
        acc_cyc = -1;
        data_i  = b;
        valid_i = 1'b1;
        for (int n = 0; n < 8 * FRAME1 && !ok; n++) begin
            r = ready;
            tick();
            if (r === 1'b1) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(b);
            end
        end
        checkOutput("push_accepted", 32'(ok), 1);
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic compareRx(input string tag);
        checkOutput({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        checkOutput({tag, "_framing"}, frame_err, 0);
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
    endtask

    task automatic monWait(input int n, inout bit ab);
        for (int i = 0; i < n && !ab; i++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) ab = 1'b1;
        end
    endtask

    // Receiver on the STOP_BITS=1 instance; a reset during a frame abandons it.
    initial begin : uart_monitor
        logic [7:0] mb;
        bit         ab;
        int         st;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                mb = '0;
                monWait(CPB / 2, ab);
                if (!ab && tx !== 1'b0) frame_err++;
                for (int k = 0; k < 8; k++) begin
                    monWait(CPB, ab);
                    mb[k] = tx;
                end
                monWait(CPB, ab);
                if (!ab && tx !== 1'b1) frame_err++;
                if (!ab) begin
                    rx_q.push_back(mb);
                    start_q.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int         acc[6];
        int         mism;
        int         peak;
        int         n;
        int         s;
        bit         dup;
        logic [7:0] bytes[6];
        logic [7:0] b;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        valid2  = 1'b0;
        data2   = '0;
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("rst_tx", 32'(tx), 1);
        checkOutput("rst_ready", 32'(ready), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_tx2", 32'(tx2), 1);
        rst_n = 1'b1;

        $display("[TB] idle hold");
        mism = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) mism++;
        end
        checkOutput("idle_hold", mism, 0);

        $display("[TB] single byte 0x41");
        applyStimulus(8'h41, acc[0]);
        valid_i = 1'b0;
        checkOutput("single_level_accept", 32'(level), 1);
        checkOutput("single_busy_accept", 32'(busy), 1);
        mism = 0;
        for (int t = 0; t < FRAME1; t++) begin
            tick();
            if (tx !== expTx(8'h41, t)) mism++;
            if (t == 0) checkOutput("single_level_pop", 32'(level), 0);
        end
        checkOutput("single_wave", mism, 0);
        checkOutput("single_busy_last", 32'(busy), 1);
        tick();
        checkOutput("single_busy_drop", 32'(busy), 0);
        s = (start_q.size() > 0) ? start_q[0] : -1;
        checkOutput("single_start_cycle", s, acc[0] + 1);
        compareRx("single");

        $display("[TB] back-to-back 0x55 0xAA");
        applyStimulus(8'h55, acc[0]);
        peak = int'(level);
        applyStimulus(8'hAA, acc[1]);
        valid_i = 1'b0;
        if (int'(level) > peak) peak = int'(level);
        checkOutput("b2b_consecutive", acc[1] - acc[0], 1);
        n = 0;
        while (busy !== 1'b0 && n < 3 * FRAME1) begin
            tick();
            n++;
            if (int'(level) > peak) peak = int'(level);
        end
        checkOutput("b2b_idle", 32'(busy), 0);
        checkOutput("b2b_peak", peak, 1);
        s = (start_q.size() > 0) ? start_q[0] : -1;
        checkOutput("b2b_first_start", s, acc[0] + 1);
        s = (start_q.size() > 1) ? start_q[1] - start_q[0] : -1;
        checkOutput("b2b_gap", s, FRAME1);
        compareRx("b2b");

        $display("[TB] backpressure with six bytes");
        for (int i = 0; i < 6; i++) begin
            do begin
                bytes[i] = 8'($urandom);
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (bytes[j] == bytes[i]) dup = 1'b1;
            end while (dup);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(bytes[i], acc[i]);
            if (i == 4) begin
                checkOutput("bp_ready_full", 32'(ready), 0);
                checkOutput("bp_level_full", 32'(level), 4);
            end
        end
        valid_i = 1'b0;
        checkOutput("bp_fill_cycles", acc[4] - acc[0], 4);
        checkOutput("bp_sixth_accept", acc[5] - acc[0], FRAME1 + 2);
        waitIdle("bp", 7 * FRAME1);
        compareRx("bp");

        $display("[TB] reset mid-frame");
        b = 8'($urandom);
        applyStimulus(b, acc[0]);
        applyStimulus(8'($urandom), acc[1]);
        applyStimulus(8'($urandom), acc[2]);
        valid_i = 1'b0;
        checkOutput("rstmid_queued", 32'(level), 2);
        n = 0;
        while (cyc < acc[0] + 1 + 4 * CPB + CPB / 2 && n < FRAME1) begin
            tick();
            n++;
        end
        checkOutput("rstmid_bit3", 32'(tx), 32'(b[3]));
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_tx", 32'(tx), 1);
        checkOutput("rstmid_level", 32'(level), 0);
        checkOutput("rstmid_ready", 32'(ready), 1);
        checkOutput("rstmid_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        mism = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || level !== '0) mism++;
        end
        checkOutput("rstmid_quiet", mism, 0);
        compareRx("rstmid");

        $display("[TB] random bytes with random gaps");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'($urandom), s);
            valid_i = 1'b0;
            repeat ($urandom_range(0, 1500)) tick();
        end
        waitIdle("rand", 6 * FRAME1);
        compareRx("rand");

        $display("[TB] two stop bits, byte 0xFF");
        data2  = 8'hFF;
        valid2 = 1'b1;
        checkOutput("s2_ready", 32'(ready2), 1);
        tick();
        valid2 = 1'b0;
        checkOutput("s2_level", 32'(level2), 1);
        mism = 0;
        for (int t = 0; t < FRAME2; t++) begin
            tick();
            if (tx2 !== expTx(8'hFF, t)) mism++;
        end
        checkOutput("s2_wave", mism, 0);
        checkOutput("s2_busy_last", 32'(busy2), 1);
        tick();
        checkOutput("s2_busy_drop", 32'(busy2), 0);
        checkOutput("s2_tx_idle", 32'(tx2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
